// File: rtl/coleta_votos.sv
// Ballot collector: opens a session on start, captures one yes/no ballot per voter,
// closes on full vote or timeout and publishes V for one cycle. Optional: REVOTE_EN.
module coleta_votos #(
  parameter int N_VOTERS    = 3,
  parameter int TIMEOUT_CYC = 1000,
  localparam int TW         = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_yes,
  output logic                busy,
  output logic [N_VOTERS-1:0] voted,
  output logic [N_VOTERS-1:0] V,
  output logic                V_valid,
  output logic                timed_out,
  output logic                dup_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OPEN    = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [N_VOTERS-1:0] r_voted;
  logic [N_VOTERS-1:0] r_ballot;
  logic [N_VOTERS-1:0] r_V;
  logic [TW-1:0]       r_timer;
  logic                r_timed_out;
  logic                r_dup_err;

  logic [N_VOTERS-1:0] w_voted_next;
  logic [N_VOTERS-1:0] w_ballot_next;
  logic                w_all_voted;
  logic                w_timeout;
  logic                w_close;
  logic                w_dup;

  always_comb begin
    w_voted_next = r_voted | vote_valid;
`ifdef REVOTE_EN
    // Every strobe overwrites, including repeats.
    w_ballot_next = (r_ballot & ~vote_valid) | (vote_yes & vote_valid);
    w_dup         = 1'b0;
`else
    // Only first ballots are written; repeats are flagged.
    w_ballot_next = (r_ballot & ~(vote_valid & ~r_voted)) | (vote_yes & vote_valid & ~r_voted);
    w_dup         = |(vote_valid & r_voted);
`endif
    w_all_voted = &w_voted_next;
    w_timeout   = (r_timer == TW'(TIMEOUT_CYC - 1));
    w_close     = w_all_voted | w_timeout;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_next = S_OPEN;
      S_OPEN:    if (w_close) w_state_next = S_PUBLISH;
      S_PUBLISH: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_voted     <= '0;
      r_ballot    <= '0;
      r_V         <= '0;
      r_timer     <= '0;
      r_timed_out <= 1'b0;
      r_dup_err   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_dup_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_voted  <= '0;
            r_ballot <= '0;
            r_timer  <= '0;
          end
        end
        S_OPEN: begin
          r_voted   <= w_voted_next;
          r_ballot  <= w_ballot_next;
          r_dup_err <= w_dup;
          if (r_timer != TW'(TIMEOUT_CYC)) r_timer <= r_timer + TW'(1);
          if (w_close) begin
            r_V         <= w_ballot_next;
            r_timed_out <= ~w_all_voted;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign V_valid   = (r_state == S_PUBLISH);
  assign voted     = r_voted;
  assign V         = r_V;
  assign timed_out = r_timed_out;
  assign dup_err   = r_dup_err;

endmodule

// File: tb/tb_coleta_votos.sv
// Bench for coleta_votos (N_VOTERS=3, TIMEOUT_CYC=8): session-level model checked every
// cycle plus directed literal expectations. Honours REVOTE_EN when defined.
module tb_coleta_votos;
  localparam int NV  = 3;
  localparam int TOC = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NV-1:0] vote_valid = '0;
  logic [NV-1:0] vote_yes = '0;
  logic          busy, V_valid, timed_out, dup_err;
  logic [NV-1:0] voted, V;

  int checks = 0;
  int errors = 0;

  coleta_votos #(.N_VOTERS(NV), .TIMEOUT_CYC(TOC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vote_valid), .vote_yes(vote_yes),
    .busy(busy), .voted(voted), .V(V), .V_valid(V_valid), .timed_out(timed_out),
    .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  // Session-level model: collecting flag, cycles elapsed since start, per-voter arrays.
  bit collecting, publishing;
  int elapsed;
  bit ballots  [NV];
  bit has_voted[NV];
  logic [NV-1:0] m_V;
  bit m_to, m_dup;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NV-1:0] pack_voted();
    logic [NV-1:0] r;
    for (int i = 0; i < NV; i++) r[i] = has_voted[i];
    return r;
  endfunction

  task automatic model_reset();
    collecting = 0; publishing = 0; elapsed = 0; m_V = '0; m_to = 0; m_dup = 0;
    for (int i = 0; i < NV; i++) begin ballots[i] = 0; has_voted[i] = 0; end
  endtask

  task automatic model_step(input logic s, input logic [NV-1:0] vv, input logic [NV-1:0] vy);
    int n_voted;
    m_dup = 0;
    if (publishing) begin
      publishing = 0;
    end else if (!collecting) begin
      if (s) begin
        collecting = 1; elapsed = 0;
        for (int i = 0; i < NV; i++) begin ballots[i] = 0; has_voted[i] = 0; end
      end
    end else begin
      elapsed++;
      for (int i = 0; i < NV; i++) begin
        if (vv[i]) begin
          if (!has_voted[i]) begin
            ballots[i] = vy[i]; has_voted[i] = 1;
          end else begin
`ifdef REVOTE_EN
            ballots[i] = vy[i];
`else
            m_dup = 1;
`endif
          end
        end
      end
      n_voted = 0;
      for (int i = 0; i < NV; i++) n_voted += int'(has_voted[i]);
      if (n_voted == NV || elapsed == TOC) begin
        collecting = 0; publishing = 1;
        for (int i = 0; i < NV; i++) m_V[i] = ballots[i];
        m_to = (n_voted != NV);
      end
    end
  endtask

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(collecting | publishing));
    chk("V_valid", 32'(V_valid), 32'(publishing));
    chk("voted", 32'(voted), 32'(pack_voted()));
    chk("V", 32'(V), 32'(m_V));
    chk("timed_out", 32'(timed_out), 32'(m_to));
    chk("dup_err", 32'(dup_err), 32'(m_dup));
  end

  task automatic tick(input logic s, input logic [NV-1:0] vv, input logic [NV-1:0] vy);
    start = s; vote_valid = vv; vote_yes = vy;
    @(posedge clk);
    if (rst_n) model_step(s, vv, vy);
    #1;
    start = 0; vote_valid = '0; vote_yes = '0;
  endtask

  int  n;
  bit  seen_dup, seen_valid;

  initial begin
    model_reset();
    repeat (2) tick(0, '0, '0);
    rst_n = 1'b1;
    tick(0, '0, '0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_V", 32'(V), 32'd0);

    // Separate-cycle votes v0=1, v1=0, v2=1
    tick(1, 3'b000, 3'b000);
    chk("t2_busy", 32'(busy), 32'd1);
    tick(0, 3'b001, 3'b001);
    tick(0, 3'b010, 3'b000);
    chk("t2_not_yet", 32'(V_valid), 32'd0);
    tick(0, 3'b100, 3'b100);
    chk("t2_V_valid", 32'(V_valid), 32'd1);
    chk("t2_V", 32'(V), 32'b101);
    chk("t2_timed_out", 32'(timed_out), 32'd0);
    chk("t2_voted", 32'(voted), 32'b111);
    tick(0, '0, '0);
    chk("t2_pulse_end", 32'(V_valid), 32'd0);
    chk("t2_voted_held", 32'(voted), 32'b111);

    // Asynchronous reset asserted mid-cycle
    #2; rst_n = 1'b0; model_reset();
    #1;
    chk("t1_V", 32'(V), 32'd0);
    chk("t1_V_valid", 32'(V_valid), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_voted", 32'(voted), 32'd0);
    tick(0, '0, '0);
    rst_n = 1'b1;
    tick(0, '0, '0);

    // Timeout: only v1 votes yes
    tick(1, '0, '0);
    n = 0; seen_valid = 0;
    while (!seen_valid && n < 20) begin
      if (n == 0) tick(0, 3'b010, 3'b010); else tick(0, '0, '0);
      n++;
      seen_valid = V_valid;
    end
    chk("t3_latency", 32'(n), 32'd8);
    chk("t3_V", 32'(V), 32'b010);
    chk("t3_timed_out", 32'(timed_out), 32'd1);
    tick(0, '0, '0);
    chk("t3_timed_out_held", 32'(timed_out), 32'd1);

    // Repeat vote from v0
    tick(1, '0, '0);
    tick(0, 3'b001, 3'b001);
    tick(0, 3'b001, 3'b000);
    seen_dup = dup_err;
    tick(0, 3'b110, 3'b000);
    chk("t4_dup_cleared", 32'(dup_err), 32'd0);
    chk("t4_V_valid", 32'(V_valid), 32'd1);
`ifdef REVOTE_EN
    chk("t4_dup_seen", 32'(seen_dup), 32'd0);
    chk("t4_V", 32'(V), 32'b000);
`else
    chk("t4_dup_seen", 32'(seen_dup), 32'd1);
    chk("t4_V", 32'(V), 32'b001);
`endif
    chk("t4_timed_out", 32'(timed_out), 32'd0);
    tick(0, '0, '0);

    // All voters in one cycle
    tick(1, '0, '0);
    tick(0, 3'b111, 3'b111);
    chk("t5_V_valid", 32'(V_valid), 32'd1);
    chk("t5_V", 32'(V), 32'b111);
    tick(0, '0, '0);

    // Votes in the timeout edge still count as full voting
    tick(1, '0, '0);
    for (int k = 0; k < TOC - 1; k++) tick(0, '0, '0);
    tick(0, 3'b111, 3'b011);
    chk("t7_V_valid", 32'(V_valid), 32'd1);
    chk("t7_V", 32'(V), 32'b011);
    chk("t7_timed_out", 32'(timed_out), 32'd0);
    tick(0, '0, '0);

    // Reset mid-session discards it
    tick(1, '0, '0);
    tick(0, 3'b001, 3'b001);
    tick(0, 3'b010, 3'b010);
    #2; rst_n = 1'b0; model_reset();
    #1;
    chk("t6_V", 32'(V), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    seen_valid = 0;
    for (int k = 0; k < 3; k++) begin
      tick(0, '0, '0);
      seen_valid = seen_valid | V_valid;
    end
    rst_n = 1'b1;
    tick(0, 3'b111, 3'b111);
    tick(0, 3'b111, 3'b101);
    chk("t6_no_V_valid", 32'(seen_valid | V_valid), 32'd0);
    chk("t6_idle_voted", 32'(voted), 32'd0);
    chk("t6_idle_dup", 32'(dup_err), 32'd0);
    tick(0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end
endmodule
